// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port, 16-bit word-addressed memory between the CPU's
//   fetch (I) and data (D) requesters. One access is outstanding at a time:
//   IDLE grants, ACCESS holds the memory bus for LATENCY cycles (mem_en only
//   on the last one), RESP pulses the owner's done for one cycle.
//
//   Ports
//     clk, rst                     clock, synchronous active-high reset
//     i_req/i_addr                 fetch read request (held until i_done)
//     i_rdata/i_done               registered fetch data, completion pulse
//     d_req/d_wr/d_addr/d_wdata    data request (held until d_done)
//     d_rdata/d_done               registered data read value, completion pulse
//     mem_en/mem_wr/mem_addr/mem_wdata  memory control
//     mem_rdata                    memory read data, combinational from mem_addr
//
//   Configuration
//     MEM_ARB_RR_EN  defined: round-robin on simultaneous requests.
//                    undefined: D always wins a tie.
module mem_arbiter #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t           state_q, state_d;
  logic             own_is_d_q, own_is_d_d;   // owner of the transaction: 1 = D
  logic             wr_q, wr_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      i_rdata_q, d_rdata_q;
  logic             gnt_is_d;                 // who would win if granted now
  logic             last_cyc;                 // final ACCESS cycle, memory acts
  logic             live;                     // outputs forced low during rst

  assign last_cyc = (state_q == ACCESS) && (cnt_q == '0);
  assign live     = ~rst;

`ifdef MEM_ARB_RR_EN
  // Remembers who won the previous grant so a tie goes to the other side.
  // Resets to "I won last", so D takes the first tie.
  logic last_was_d_q;

  assign gnt_is_d = d_req & (~i_req | ~last_was_d_q);

  always_ff @(posedge clk) begin
    if (rst)
      last_was_d_q <= 1'b0;
    else if (state_q == IDLE && (i_req | d_req))
      last_was_d_q <= gnt_is_d;
  end
`else
  // Fixed priority: a stalled data access must never wait behind fetch.
  assign gnt_is_d = d_req;
`endif

  always_comb begin
    state_d    = state_q;
    own_is_d_d = own_is_d_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          own_is_d_d = gnt_is_d;
          wr_d       = gnt_is_d & d_wr;
          addr_d     = gnt_is_d ? d_addr  : i_addr;
          wdata_d    = gnt_is_d ? d_wdata : 16'h0000;
          cnt_d      = CNT_LOAD;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      own_is_d_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      own_is_d_q <= own_is_d_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      // Reads land in the owner's register on the same edge the memory acts.
      if (last_cyc && !wr_q) begin
        if (own_is_d_q) d_rdata_q <= mem_rdata;
        else            i_rdata_q <= mem_rdata;
      end
    end
  end

  // The memory bus is only driven in ACCESS; rst suppresses it combinationally
  // so an access whose final edge coincides with rst never commits.
  always_comb begin
    mem_en    = live & last_cyc;
    mem_wr    = live & (state_q == ACCESS) & wr_q;
    mem_addr  = (live && state_q == ACCESS) ? addr_q  : 16'h0000;
    mem_wdata = (live && state_q == ACCESS) ? wdata_q : 16'h0000;
    i_done    = live & (state_q == RESP) & ~own_is_d_q;
    d_done    = live & (state_q == RESP) &  own_is_d_q;
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Bench for mem_arbiter with LATENCY=3 against a word memory model.
//   Directed transaction table, tie/alternation, reset-mid-access and
//   back-to-back sequences, then random traffic checked against a
//   transaction-level timing/data model.
module tb_mem_arbiter;

  localparam int LAT  = 3;
  localparam int NRND = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        i_done, d_done, mem_en, mem_wr;

  logic [15:0] mem    [0:65535];
  logic [15:0] mmodel [0:65535];
  logic        init_req = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(LAT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [15:0] preload(input int a);
    if (a == 16'h0010) return 16'hBEEF;
    return 16'(a) ^ 16'h5A5A;
  endfunction

  // Memory: asynchronous read, write on clock edge when enabled.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (init_req) begin
      for (int a = 0; a < 65536; a++) mem[a] <= preload(a);
    end else if (mem_en && mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;   // owner's rdata at done (unchanged for writes)
  } vec_t;

  // Starts in an IDLE cycle (just after posedge); returns in the next IDLE cycle.
  task automatic run_txn(input vec_t v, input string nm);
    int done_at, en_cnt, en_at;
    bit other;
    logic en_wr;
    logic [15:0] en_addr, en_wdata;
    done_at = -1; en_cnt = 0; en_at = -1; other = 1'b0;
    en_wr = 1'b0; en_addr = '0; en_wdata = '0;
    if (v.is_d) begin
      d_req = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++; en_at = k; en_wr = mem_wr; en_addr = mem_addr; en_wdata = mem_wdata;
      end
      if (v.is_d ? i_done : d_done) other = 1'b1;
      if (v.is_d ? d_done : i_done) begin
        done_at = k;
        break;
      end
      tick();
    end
    chk({nm, "_latency"}, 80'(done_at), 80'(LAT + 1));
    chk({nm, "_en_once"}, {en_cnt, en_at}, {32'd1, 32'(LAT)});
    chk({nm, "_bus"}, {en_wr, en_addr, v.wr ? en_wdata : 16'h0},
                      {v.wr, v.addr, v.wr ? v.wdata : 16'h0});
    chk({nm, "_rdata"}, {other, v.is_d ? d_rdata : i_rdata}, {1'b0, v.exp_rdata});
    tick();
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [10];
    int d_at, i_at, n, last_at;
    logic [3:0] ord, exp_ord;
    bit seen;

    // ---------------- reset state ----------------
    tick();
    init_req = 1'b0;
    tick();
    @(negedge clk);
    chk("reset_outputs",
        {i_done, d_done, mem_en, mem_wr, mem_addr, mem_wdata, i_rdata, d_rdata}, 80'h0);
    tick();
    rst = 1'b0;

    // ---------------- single-requester transaction table ----------------
    vt[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vt[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000};
    vt[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234};
    vt[3] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234};
    vt[4] = '{1'b1, 1'b1, 16'h0010, 16'hCAFE, 16'h1234};
    vt[5] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hCAFE};
    vt[6] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5};
    vt[7] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'hA5A5};
    vt[8] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0001};
    vt[9] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h5A5A};
    for (int t = 0; t < 10; t++) run_txn(vt[t], $sformatf("tbl%0d", t));

    // ---------------- tie from reset: D first, I LAT+2 later ----------------
    rst_pulse();
    i_req = 1'b1; i_addr = 16'h0010;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
    d_at = -1; i_at = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      seen = d_done;
      if (d_done && d_at < 0) d_at = k;
      if (i_done && i_at < 0) i_at = k;
      if (i_at >= 0) break;
      tick();
      if (seen) d_req = 1'b0;
    end
    chk("tie_d_first", 80'(d_at), 80'(LAT + 1));
    chk("tie_i_after", 80'(i_at), 80'(2 * LAT + 3));
    chk("tie_rdata", {i_rdata, d_rdata}, {16'hCAFE, 16'h1234});
    tick();
    i_req = 1'b0; d_req = 1'b0;

    // ---------------- both held: grant order ----------------
    rst_pulse();
    i_req = 1'b1; i_addr = 16'h0010;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
    n = 0; ord = '0; last_at = -1;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk);
      if (i_done || d_done) begin
        ord[n] = d_done;
        last_at = k;
        n++;
      end
      if (n < 4) tick();
    end
`ifdef MEM_ARB_RR_EN
    exp_ord = 4'b0101;
`else
    exp_ord = 4'b1111;
`endif
    chk("both_order", ord, exp_ord);
    chk("both_timing", 80'(last_at), 80'((LAT + 1) + 3 * (LAT + 2)));
    tick();
    i_req = 1'b0; d_req = 1'b0;

    // ---------------- rst during ACCESS of a write ----------------
    for (int k = 1; k <= LAT; k++) begin
      vec_t rb;
      int stray;
      rst_pulse();
      d_req = 1'b1; d_wr = 1'b1; d_addr = 16'(16'h0030 + k); d_wdata = 16'(16'h7700 + k);
      for (int j = 0; j < k; j++) tick();
      d_req = 1'b0; d_wr = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk($sformatf("rst_at%0d_quiet", k), {mem_en, mem_wr, d_done}, 80'h0);
      tick();
      rst = 1'b0;
      stray = 0;
      for (int j = 0; j < 2 * LAT + 4; j++) begin
        @(negedge clk);
        if (d_done || i_done || mem_en) stray++;
        tick();
      end
      chk($sformatf("rst_at%0d_no_done", k), 80'(stray), 80'h0);
      chk($sformatf("rst_at%0d_mem", k), mem[16'h0030 + k], preload(16'h0030 + k));
      rb = '{1'b1, 1'b0, 16'(16'h0030 + k), 16'h0000, preload(16'h0030 + k)};
      run_txn(rb, $sformatf("rst_at%0d_after", k));
    end

    // ---------------- back-to-back fetch, address stepped each done ----------------
    rst_pulse();
    i_req = 1'b1; i_addr = 16'h0100;
    n = 0;
    for (int k = 0; k < 5 * (LAT + 2) + 4; k++) begin
      @(negedge clk);
      seen = i_done;
      if (d_done) chk("b2b_no_d_done", 80'(d_done), 80'h0);
      if (i_done) begin
        if (n < 5) begin
          chk($sformatf("b2b%0d_cycle", n), 80'(k), 80'((LAT + 1) + n * (LAT + 2)));
          chk($sformatf("b2b%0d_rdata", n), i_rdata, preload(16'h0100 + n));
        end
        n++;
      end
      tick();
      if (seen) begin
        if (n < 5) i_addr = 16'(16'h0100 + n);
        else       i_req  = 1'b0;
      end
    end
    chk("b2b_count", 80'(n), 80'd5);

    // ---------------- random traffic vs transaction model ----------------
    begin
      int free_cyc, p_done;
      bit pend, p_d, p_wr, last_d, win_d, sid, sdd;
      logic [15:0] p_addr, p_wdata, exp_i, exp_d;
      bit exp_id, exp_dd, exp_en;

      rst_pulse();
      for (int a = 0; a < 65536; a++) mmodel[a] = mem[a];
      free_cyc = 0; pend = 1'b0; last_d = 1'b0; exp_i = '0; exp_d = '0;
      p_d = 1'b0; p_wr = 1'b0; p_addr = '0; p_wdata = '0; p_done = 0;
      for (int c = 0; c < NRND; c++) begin
        @(negedge clk);
        exp_en = pend && (c == p_done - 1);
        exp_id = pend && (c == p_done) && !p_d;
        exp_dd = pend && (c == p_done) &&  p_d;
        if (pend && c == p_done) begin
          if (p_wr)     mmodel[p_addr] = p_wdata;
          else if (p_d) exp_d = mmodel[p_addr];
          else          exp_i = mmodel[p_addr];
          pend = 1'b0;
        end
        chk("rand_cycle", {i_done, d_done, mem_en, i_rdata, d_rdata},
                          {exp_id, exp_dd, exp_en, exp_i, exp_d});
        if (exp_en)
          chk("rand_bus", {mem_wr, mem_addr, p_wr ? mem_wdata : 16'h0},
                          {p_wr, p_addr, p_wr ? p_wdata : 16'h0});
        if (c >= free_cyc && (i_req || d_req)) begin
`ifdef MEM_ARB_RR_EN
          win_d = d_req && (!i_req || !last_d);
`else
          win_d = d_req;
`endif
          last_d   = win_d;
          pend     = 1'b1;
          p_d      = win_d;
          p_wr     = win_d && d_wr;
          p_addr   = win_d ? d_addr : i_addr;
          p_wdata  = d_wdata;
          p_done   = c + LAT + 1;
          free_cyc = c + LAT + 2;
        end
        sid = i_done; sdd = d_done;
        tick();
        if (!i_req || sid) begin
          if ($urandom_range(0, 2) != 0) begin
            i_req = 1'b1; i_addr = 16'(16'h0040 + $urandom_range(0, 7));
          end else begin
            i_req = 1'b0; i_addr = 16'($urandom);
          end
        end
        if (!d_req || sdd) begin
          if ($urandom_range(0, 2) != 0) begin
            d_req = 1'b1; d_wr = 1'($urandom_range(0, 1));
            d_addr = 16'(16'h0040 + $urandom_range(0, 7)); d_wdata = 16'($urandom);
          end else begin
            d_req = 1'b0; d_wr = 1'($urandom_range(0, 1));
            d_addr = 16'($urandom); d_wdata = 16'($urandom);
          end
        end
      end
      i_req = 1'b0; d_req = 1'b0;
      for (int j = 0; j < LAT + 3; j++) tick();
      for (int a = 16'h0040; a < 16'h0048; a++)
        chk($sformatf("rand_mem_%0h", a), mem[a], mmodel[a]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
